// File: rtl/qpu_exu_oitf_pkg.sv
// Shared widths, depths and entry types for the execute-unit outstanding
// instruction tracker.
package qpu_exu_oitf_pkg;

  localparam int QPU_RFIDX_REAL_WIDTH = 5;
  localparam int QPU_QUBIT_NUM        = 4;
  localparam int QPU_OITF_DEPTH       = 2;
  localparam int QPU_MOITF_DEPTH      = 4;

  typedef struct packed {
    logic                            rdwen;
    logic [QPU_RFIDX_REAL_WIDTH-1:0] rdidx;
  } oitf_entry_t;

endpackage

// File: rtl/qpu_oitf_ptr.sv
// Ring pointer with wrap flag; the flag tells a full ring from an empty one
// when read and write pointers are equal.
module qpu_oitf_ptr #(
  parameter int DEPTH = 2,
  parameter int PW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          inc,
  output logic [PW-1:0] ptr,
  output logic          flag
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr  <= '0;
      flag <= 1'b0;
    end else if (inc) begin
      if (ptr == PW'(DEPTH - 1)) begin
        ptr  <= '0;
        flag <= ~flag;
      end else begin
        ptr <= ptr + 1'b1;
      end
    end
  end

endmodule

// File: rtl/qpu_exu_oitf.sv
// Outstanding instruction track FIFOs: long-pipe destination registers and
// measure qubit masks, with combinational hazard flags back to dispatch.
module qpu_exu_oitf
  import qpu_exu_oitf_pkg::*;
#(
  parameter int OITF_DEPTH  = QPU_OITF_DEPTH,
  parameter int MOITF_DEPTH = QPU_MOITF_DEPTH
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            dis_ena,
  output logic                            dis_ready,
  input  logic                            mdis_ena,
  output logic                            mdis_ready,
  input  logic                            disp_rs1en,
  input  logic                            disp_rs2en,
  input  logic                            disp_rdwen,
  input  logic                            disp_qfren,
  input  logic [QPU_RFIDX_REAL_WIDTH-1:0] disp_rs1idx,
  input  logic [QPU_RFIDX_REAL_WIDTH-1:0] disp_rs2idx,
  input  logic [QPU_RFIDX_REAL_WIDTH-1:0] disp_rdidx,
  input  logic [QPU_QUBIT_NUM-1:0]        disp_qubitlist,
  output logic                            oitfrd_match_disprs1,
  output logic                            oitfrd_match_disprs2,
  output logic                            oitfrd_match_disprd,
  output logic                            oitfqf_match_dispql,
  input  logic                            ret_ena,
  output logic                            ret_rdwen,
  output logic [QPU_RFIDX_REAL_WIDTH-1:0] ret_rdidx,
  input  logic                            mret_ena,
  output logic [QPU_QUBIT_NUM-1:0]        mret_qubitlist,
  output logic                            oitf_empty,
  output logic                            moitf_empty
);

  localparam int QN  = QPU_QUBIT_NUM;
  localparam int OPW = $clog2(OITF_DEPTH);
  localparam int MPW = $clog2(MOITF_DEPTH);

  // ---------------- long-pipe FIFO ----------------
  logic [OPW-1:0] o_wptr, o_rptr;
  logic           o_wflag, o_rflag;
  logic           o_full, o_alloc, o_ret;

  assign oitf_empty = (o_wptr == o_rptr) && (o_wflag == o_rflag);
  assign o_full     = (o_wptr == o_rptr) && (o_wflag != o_rflag);
  assign dis_ready  = !o_full;
  assign o_alloc    = dis_ena && !o_full;
  assign o_ret      = ret_ena && !oitf_empty;

  qpu_oitf_ptr #(.DEPTH(OITF_DEPTH)) u_o_wptr (
    .clk(clk), .rst_n(rst_n), .inc(o_alloc), .ptr(o_wptr), .flag(o_wflag)
  );
  qpu_oitf_ptr #(.DEPTH(OITF_DEPTH)) u_o_rptr (
    .clk(clk), .rst_n(rst_n), .inc(o_ret), .ptr(o_rptr), .flag(o_rflag)
  );

  oitf_entry_t            o_ent [OITF_DEPTH];
  logic [OITF_DEPTH-1:0]  hit_rs1, hit_rs2, hit_rd;

  for (genvar i = 0; i < OITF_DEPTH; i++) begin : g_oitf
    logic        vld;
    oitf_entry_t ent;

    // Alloc and retire never target the same slot: that would need an empty
    // FIFO, where retire is ignored.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        vld <= 1'b0;
        ent <= '0;
      end else if (o_alloc && (o_wptr == OPW'(i))) begin
        vld <= 1'b1;
        ent <= '{rdwen: disp_rdwen, rdidx: disp_rdidx};
      end else if (o_ret && (o_rptr == OPW'(i))) begin
        vld <= 1'b0;
      end
    end

    assign o_ent[i]   = ent;
    assign hit_rs1[i] = vld && ent.rdwen && (ent.rdidx == disp_rs1idx);
    assign hit_rs2[i] = vld && ent.rdwen && (ent.rdidx == disp_rs2idx);
    assign hit_rd[i]  = vld && ent.rdwen && (ent.rdidx == disp_rdidx);
  end

  assign oitfrd_match_disprs1 = disp_rs1en && (|hit_rs1);
  assign oitfrd_match_disprs2 = disp_rs2en && (|hit_rs2);
  assign oitfrd_match_disprd  = disp_rdwen && (|hit_rd);

  assign ret_rdwen = !oitf_empty && o_ent[o_rptr].rdwen;
  assign ret_rdidx = oitf_empty ? '0 : o_ent[o_rptr].rdidx;

  // ---------------- measure FIFO ----------------
  logic [MPW-1:0] m_wptr, m_rptr;
  logic           m_wflag, m_rflag;
  logic           m_full, m_alloc, m_ret;

  assign moitf_empty = (m_wptr == m_rptr) && (m_wflag == m_rflag);
  assign m_full      = (m_wptr == m_rptr) && (m_wflag != m_rflag);
  assign mdis_ready  = !m_full;
  assign m_alloc     = mdis_ena && !m_full;
  assign m_ret       = mret_ena && !moitf_empty;

  qpu_oitf_ptr #(.DEPTH(MOITF_DEPTH)) u_m_wptr (
    .clk(clk), .rst_n(rst_n), .inc(m_alloc), .ptr(m_wptr), .flag(m_wflag)
  );
  qpu_oitf_ptr #(.DEPTH(MOITF_DEPTH)) u_m_rptr (
    .clk(clk), .rst_n(rst_n), .inc(m_ret), .ptr(m_rptr), .flag(m_rflag)
  );

  logic [QN-1:0] m_ql   [MOITF_DEPTH];
  logic [QN-1:0] m_pend [MOITF_DEPTH];

  for (genvar i = 0; i < MOITF_DEPTH; i++) begin : g_moitf
    logic          vld;
    logic [QN-1:0] ql;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        vld <= 1'b0;
        ql  <= '0;
      end else if (m_alloc && (m_wptr == MPW'(i))) begin
        vld <= 1'b1;
        ql  <= disp_qubitlist;
      end else if (m_ret && (m_rptr == MPW'(i))) begin
        vld <= 1'b0;
      end
    end

    assign m_ql[i]   = ql;
    assign m_pend[i] = vld ? ql : '0;
  end

  logic [QN-1:0] pending_mask;

  always_comb begin
    pending_mask = '0;
    for (int k = 0; k < MOITF_DEPTH; k++) pending_mask = pending_mask | m_pend[k];
  end

  assign oitfqf_match_dispql = disp_qfren && (|(disp_qubitlist & pending_mask));
  assign mret_qubitlist      = moitf_empty ? '0 : m_ql[m_rptr];

  // Dispatch must gate its enables with ready/empty; these catch violations.
  a_oitf_ovf:  assert property (@(posedge clk) disable iff (!rst_n) !(dis_ena && o_full));
  a_oitf_udf:  assert property (@(posedge clk) disable iff (!rst_n) !(ret_ena && oitf_empty));
  a_moitf_ovf: assert property (@(posedge clk) disable iff (!rst_n) !(mdis_ena && m_full));
  a_moitf_udf: assert property (@(posedge clk) disable iff (!rst_n) !(mret_ena && moitf_empty));

endmodule

// File: tb/tb_qpu_exu_oitf.sv
// Random legal dispatch/retire traffic against a queue-based reference model;
// a monitor compares every cycle's outputs with the model's prediction.
module tb_qpu_exu_oitf;
  import qpu_exu_oitf_pkg::*;

  localparam int RW = QPU_RFIDX_REAL_WIDTH;
  localparam int QN = QPU_QUBIT_NUM;
  localparam int OD = QPU_OITF_DEPTH;
  localparam int MD = QPU_MOITF_DEPTH;

  logic          clk, rst_n;
  logic          dis_ena, dis_ready, mdis_ena, mdis_ready;
  logic          disp_rs1en, disp_rs2en, disp_rdwen, disp_qfren;
  logic [RW-1:0] disp_rs1idx, disp_rs2idx, disp_rdidx;
  logic [QN-1:0] disp_qubitlist;
  logic          oitfrd_match_disprs1, oitfrd_match_disprs2, oitfrd_match_disprd;
  logic          oitfqf_match_dispql;
  logic          ret_ena, ret_rdwen;
  logic [RW-1:0] ret_rdidx;
  logic          mret_ena;
  logic [QN-1:0] mret_qubitlist;
  logic          oitf_empty, moitf_empty;

  qpu_exu_oitf dut (
    .clk(clk), .rst_n(rst_n),
    .dis_ena(dis_ena), .dis_ready(dis_ready),
    .mdis_ena(mdis_ena), .mdis_ready(mdis_ready),
    .disp_rs1en(disp_rs1en), .disp_rs2en(disp_rs2en),
    .disp_rdwen(disp_rdwen), .disp_qfren(disp_qfren),
    .disp_rs1idx(disp_rs1idx), .disp_rs2idx(disp_rs2idx), .disp_rdidx(disp_rdidx),
    .disp_qubitlist(disp_qubitlist),
    .oitfrd_match_disprs1(oitfrd_match_disprs1),
    .oitfrd_match_disprs2(oitfrd_match_disprs2),
    .oitfrd_match_disprd(oitfrd_match_disprd),
    .oitfqf_match_dispql(oitfqf_match_dispql),
    .ret_ena(ret_ena), .ret_rdwen(ret_rdwen), .ret_rdidx(ret_rdidx),
    .mret_ena(mret_ena), .mret_qubitlist(mret_qubitlist),
    .oitf_empty(oitf_empty), .moitf_empty(moitf_empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic          dis_ready, mdis_ready, oitf_empty, moitf_empty;
    logic          m1, m2, md, mq;
    logic          ret_rdwen;
    logic [RW-1:0] ret_rdidx;
    logic [QN-1:0] mret_ql;
  } exp_t;

  exp_t          exp_q[$];
  logic [RW:0]   oq[$];   // {rdwen, rdidx}, oldest first
  logic [QN-1:0] mq[$];
  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, req, $time);
    end
  endtask

  function automatic exp_t model();
    exp_t          e;
    logic [QN-1:0] pend;
    e = '0;
    e.dis_ready   = oq.size() < OD;
    e.mdis_ready  = mq.size() < MD;
    e.oitf_empty  = oq.size() == 0;
    e.moitf_empty = mq.size() == 0;
    foreach (oq[k]) begin
      if (oq[k][RW] && oq[k][RW-1:0] == disp_rs1idx && disp_rs1en) e.m1 = 1'b1;
      if (oq[k][RW] && oq[k][RW-1:0] == disp_rs2idx && disp_rs2en) e.m2 = 1'b1;
      if (oq[k][RW] && oq[k][RW-1:0] == disp_rdidx  && disp_rdwen) e.md = 1'b1;
    end
    pend = '0;
    foreach (mq[k]) pend = pend | mq[k];
    e.mq = disp_qfren && ((disp_qubitlist & pend) != '0);
    if (oq.size() > 0) begin
      e.ret_rdwen = oq[0][RW];
      e.ret_rdidx = oq[0][RW-1:0];
    end
    if (mq.size() > 0) e.mret_ql = mq[0];
    return e;
  endfunction

  // Monitor: one prediction per cycle, compared mid-cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("dis_ready",   32'(dis_ready),            32'(e.dis_ready));
        chk("mdis_ready",  32'(mdis_ready),           32'(e.mdis_ready));
        chk("oitf_empty",  32'(oitf_empty),           32'(e.oitf_empty));
        chk("moitf_empty", 32'(moitf_empty),          32'(e.moitf_empty));
        chk("match_rs1",   32'(oitfrd_match_disprs1), 32'(e.m1));
        chk("match_rs2",   32'(oitfrd_match_disprs2), 32'(e.m2));
        chk("match_rd",    32'(oitfrd_match_disprd),  32'(e.md));
        chk("match_ql",    32'(oitfqf_match_dispql),  32'(e.mq));
        chk("ret_rdwen",   32'(ret_rdwen),            32'(e.ret_rdwen));
        chk("ret_rdidx",   32'(ret_rdidx),            32'(e.ret_rdidx));
        chk("mret_ql",     32'(mret_qubitlist),       32'(e.mret_ql));
      end
    end
  end

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_dis_ready"},  32'(dis_ready),            32'd1);
    chk({tag, "_mdis_ready"}, 32'(mdis_ready),           32'd1);
    chk({tag, "_oempty"},     32'(oitf_empty),           32'd1);
    chk({tag, "_mempty"},     32'(moitf_empty),          32'd1);
    chk({tag, "_rs1"},        32'(oitfrd_match_disprs1), 32'd0);
    chk({tag, "_rs2"},        32'(oitfrd_match_disprs2), 32'd0);
    chk({tag, "_rd"},         32'(oitfrd_match_disprd),  32'd0);
    chk({tag, "_ql"},         32'(oitfqf_match_dispql),  32'd0);
    chk({tag, "_ret_rdwen"},  32'(ret_rdwen),            32'd0);
    chk({tag, "_ret_rdidx"},  32'(ret_rdidx),            32'd0);
    chk({tag, "_mret_ql"},    32'(mret_qubitlist),       32'd0);
  endtask

  task automatic drive_zero();
    dis_ena = 1'b0; mdis_ena = 1'b0; ret_ena = 1'b0; mret_ena = 1'b0;
    disp_rs1en = 1'b0; disp_rs2en = 1'b0; disp_rdwen = 1'b0; disp_qfren = 1'b0;
    disp_rs1idx = '0; disp_rs2idx = '0; disp_rdidx = '0; disp_qubitlist = '0;
  endtask

  // Driver: applies last cycle's accepted operations to the model, then
  // picks new legal inputs and queues the predicted outputs.
  initial begin
    logic          pd, pr, pmd, pmr;
    logic [RW:0]   pdv;
    logic [QN-1:0] pmv;
    int            n_cyc, phase, a_thr, r_thr;

    rst_n = 1'b0;
    drive_zero();
    pd = 1'b0; pr = 1'b0; pmd = 1'b0; pmr = 1'b0; pdv = '0; pmv = '0;
    #12;
    chk_reset_outputs("rst");
    @(negedge clk);
    rst_n = 1'b1;

    n_cyc = 2000;
    for (int n = 0; n <= n_cyc; n++) begin
      @(posedge clk);
      #1;
      if (pr)  void'(oq.pop_front());
      if (pd)  oq.push_back(pdv);
      if (pmr) void'(mq.pop_front());
      if (pmd) mq.push_back(pmv);

      phase = (n / 150) % 2;
      a_thr = (phase == 0) ? 3 : 1;
      r_thr = (phase == 0) ? 1 : 3;
      disp_rdwen     = 1'($urandom_range(0, 3) != 0);
      disp_rdidx     = RW'($urandom_range(0, 7));
      disp_rs1en     = 1'($urandom_range(0, 1));
      disp_rs2en     = 1'($urandom_range(0, 1));
      disp_rs1idx    = RW'($urandom_range(0, 7));
      disp_rs2idx    = RW'($urandom_range(0, 7));
      disp_qfren     = 1'($urandom_range(0, 1));
      disp_qubitlist = QN'($urandom_range(0, 15));
      if (n == n_cyc) begin
        // Leave both FIFOs non-empty for the asynchronous reset check.
        dis_ena  = oq.size() < OD;
        mdis_ena = mq.size() < MD;
        ret_ena  = 1'b0;
        mret_ena = 1'b0;
      end else begin
        dis_ena  = (oq.size() < OD) && (int'($urandom_range(0, 3)) < a_thr);
        ret_ena  = (oq.size() > 0)  && (int'($urandom_range(0, 3)) < r_thr);
        mdis_ena = (mq.size() < MD) && (int'($urandom_range(0, 3)) < a_thr);
        mret_ena = (mq.size() > 0)  && (int'($urandom_range(0, 3)) < r_thr);
      end
      pd = dis_ena;  pdv = {disp_rdwen, disp_rdidx}; pr  = ret_ena;
      pmd = mdis_ena; pmv = disp_qubitlist;          pmr = mret_ena;
      exp_q.push_back(model());
    end

    @(posedge clk);
    #1;
    if (pr)  void'(oq.pop_front());
    if (pd)  oq.push_back(pdv);
    if (pmr) void'(mq.pop_front());
    if (pmd) mq.push_back(pmv);
    drive_zero();
    disp_rs1en = 1'b1; disp_rs2en = 1'b1; disp_rdwen = 1'b1; disp_qfren = 1'b1;
    disp_rs1idx = oq[0][RW-1:0]; disp_rs2idx = oq[oq.size()-1][RW-1:0];
    disp_rdidx = oq[0][RW-1:0]; disp_qubitlist = '1;
    exp_q.push_back(model());

    for (int w = 0; w < 10 && exp_q.size() > 0; w++) @(negedge clk);
    #1;
    chk("drain", 32'(exp_q.size()), 32'd0);
    chk("pre_rst_oempty", 32'(oitf_empty),  32'd0);
    chk("pre_rst_mempty", 32'(moitf_empty), 32'd0);

    #1;
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("async_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
